alu_seq: RTL and testbench

- Parametrised, registered N-bit ALU. Successor to the 1-bit ALU slice.
- Keeps the same operand-conditioning controls: Ain (invert A), Bin (invert B), Cin (carry-in), and AND/OR/SUM operations.
- Adds SLT, a multi-cycle shift-add multiply, a start/busy/done handshake, and registered Zero/Carry/Overflow flags.
- Sits in the datapath execute stage and is driven by the control unit's ALU-control decode.

---
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered N-bit ALU: single-cycle AND/OR/SUM/SLT plus WIDTH-cycle shift-add unsigned multiply.
// Operand conditioning (Ain/Bin/Cin) applies to every Op; done pulses once per completed operation.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Ain,
  input  logic             Bin,
  input  logic             Cin,
  input  logic [2:0]       Op,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Ovf,
  output logic             flag,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_MULT} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SUM = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_ovf;
  logic               r_flag;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_aout;
  logic [WIDTH-1:0]   w_bout;
  logic [WIDTH:0]     w_sum;
  logic               w_ovf;
  logic [2*WIDTH-1:0] w_acc_step;
  logic               w_load;
  logic               w_mul_start;
  logic [WIDTH-1:0]   w_res_nxt;
  logic               w_cout_nxt;
  logic               w_ovf_nxt;

  assign w_aout = Ain ? ~a : a;
  assign w_bout = Bin ? ~b : b;
  assign w_sum  = {1'b0, w_aout} + {1'b0, w_bout} + {{WIDTH{1'b0}}, Cin};
  assign w_ovf  = (w_aout[WIDTH-1] == w_bout[WIDTH-1]) && (w_sum[WIDTH-1] != w_aout[WIDTH-1]);

  // The final iteration's add is folded in combinationally so the product is ready at E_WIDTH.
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_mul_start = 1'b0;
    w_res_nxt   = '0;
    w_cout_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (Op == OP_MUL) begin
            w_mul_start = 1'b1;
            w_state_nxt = S_MULT;
          end else begin
            w_load = 1'b1;
            case (Op)
              OP_AND: w_res_nxt = w_aout & w_bout;
              OP_OR:  w_res_nxt = w_aout | w_bout;
              OP_SUM: begin
                w_res_nxt  = w_sum[WIDTH-1:0];
                w_cout_nxt = w_sum[WIDTH];
                w_ovf_nxt  = w_ovf;
              end
              OP_SLT: begin
                w_res_nxt  = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
                w_cout_nxt = w_sum[WIDTH];
                w_ovf_nxt  = w_ovf;
              end
              default: w_res_nxt = '0;
            endcase
          end
        end
      end
      S_MULT: begin
        if (r_cnt == LAST_ITER) begin
          w_load      = 1'b1;
          w_res_nxt   = w_acc_step[WIDTH-1:0];
          w_cout_nxt  = |w_acc_step[2*WIDTH-1:WIDTH];
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_flag   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_MULT);
      r_done  <= w_load;
      if (w_load) begin
        r_result <= w_res_nxt;
        r_cout   <= w_cout_nxt;
        r_ovf    <= w_ovf_nxt;
        r_flag   <= (w_res_nxt == '0);
      end
      if (w_mul_start) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_aout};
        r_mplier <= w_bout;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_MULT) begin
        r_acc    <= w_acc_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign Result = r_result;
  assign Cout   = r_cout;
  assign Ovf    = r_ovf;
  assign flag   = r_flag;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8); outputs sampled 1 time unit after each rising edge.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       Ain;
  logic       Bin;
  logic       Cin;
  logic [2:0] Op;
  logic [7:0] Result;
  logic       Cout;
  logic       Ovf;
  logic       flag;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  alu_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .Ain    (Ain),
    .Bin    (Bin),
    .Cin    (Cin),
    .Op     (Op),
    .Result (Result),
    .Cout   (Cout),
    .Ovf    (Ovf),
    .flag   (flag),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic tai,
                       input logic tbi, input logic tci, input logic [2:0] top);
    a = ta; b = tb; Ain = tai; Bin = tbi; Cin = tci; Op = top; start = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; Ain = 1'b0; Bin = 1'b0; Cin = 1'b0; Op = '0;
    step(); step();
    chk("rst_result", Result, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_flag", flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step();
    chk("idle_done", done, 0);

    // SUM 0x7F+0x01: signed overflow into 0x80
    drive(8'h7F, 8'h01, 0, 0, 0, 3'b010);
    step(); start = 1'b0;
    chk("sum_result", Result, 8'h80);
    chk("sum_ovf", Ovf, 1);
    chk("sum_cout", Cout, 0);
    chk("sum_flag", flag, 0);
    chk("sum_done", done, 1);
    step();
    chk("sum_done_pulse", done, 0);
    chk("sum_hold", Result, 8'h80);

    // SUB 5-5
    drive(8'h05, 8'h05, 0, 1, 1, 3'b010);
    step(); start = 1'b0;
    chk("sub_result", Result, 8'h00);
    chk("sub_cout", Cout, 1);
    chk("sub_ovf", Ovf, 0);
    chk("sub_flag", flag, 1);

    // NOR, OR, reserved back to back
    drive(8'hF0, 8'h0F, 1, 1, 0, 3'b000);
    step();
    chk("nor_result", Result, 8'h00);
    chk("nor_flag", flag, 1);
    chk("nor_done", done, 1);
    drive(8'hF0, 8'h0F, 0, 0, 0, 3'b001);
    step();
    chk("or_result", Result, 8'hFF);
    chk("or_flag", flag, 0);
    chk("or_done", done, 1);
    drive(8'hFF, 8'hFF, 0, 0, 1, 3'b101);
    step(); start = 1'b0;
    chk("rsv_result", Result, 8'h00);
    chk("rsv_flag", flag, 1);
    chk("rsv_cout", Cout, 0);
    chk("rsv_done", done, 1);
    step();
    chk("rsv_done_pulse", done, 0);

    // SLT: -128 < 1 true, then 1 < -128 false
    drive(8'h80, 8'h01, 0, 1, 1, 3'b011);
    step();
    chk("slt1_result", Result, 8'h01);
    chk("slt1_cout", Cout, 1);
    chk("slt1_ovf", Ovf, 1);
    chk("slt1_flag", flag, 0);
    drive(8'h01, 8'h80, 0, 1, 1, 3'b011);
    step(); start = 1'b0;
    chk("slt2_result", Result, 8'h00);
    chk("slt2_flag", flag, 1);
    chk("slt2_cout", Cout, 0);
    chk("slt2_ovf", Ovf, 1);

    // MUL 0x10*0x12 = 0x120, accepted at E0
    drive(8'h10, 8'h12, 0, 0, 0, 3'b100);
    step(); start = 1'b0;
    chk("mul_busy_e0", busy, 1);
    chk("mul_done_e0", done, 0);
    step();
    step();
    drive(8'h01, 8'h01, 0, 0, 0, 3'b010);
    step(); start = 1'b0;
    chk("mul_busy_e3", busy, 1);
    chk("mul_ignore_e3", done, 0);
    chk("mul_hold_e3", Result, 8'h00);
    for (int i = 4; i < 8; i++) begin
      step();
      chk("mul_busy_mid", busy, 1);
      chk("mul_done_mid", done, 0);
    end
    step();
    chk("mul_done_e8", done, 1);
    chk("mul_busy_e8", busy, 0);
    chk("mul_result", Result, 8'h20);
    chk("mul_cout", Cout, 1);
    chk("mul_ovf", Ovf, 0);
    chk("mul_flag", flag, 0);
    drive(8'h01, 8'h01, 0, 0, 0, 3'b010);
    step(); start = 1'b0;
    chk("post_mul_add", Result, 8'h02);
    chk("post_mul_done", done, 1);
    chk("post_mul_busy", busy, 0);

    // Reset aborts a MUL at E4
    drive(8'h03, 8'h03, 0, 0, 0, 3'b100);
    step(); start = 1'b0;
    chk("abort_busy_e0", busy, 1);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_result", Result, 0);
    chk("abort_cout", Cout, 0);
    chk("abort_flag", flag, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    drive(8'h02, 8'h03, 0, 0, 0, 3'b010);
    step(); start = 1'b0;
    chk("abort_add_result", Result, 8'h05);
    chk("abort_add_done", done, 1);

    // Full 3*3 after recovery; product fits, so Cout clear
    drive(8'h03, 8'h03, 0, 0, 0, 3'b100);
    step(); start = 1'b0;
    for (int i = 1; i < 8; i++) step();
    chk("mul9_pre_done", done, 0);
    step();
    chk("mul9_result", Result, 8'h09);
    chk("mul9_cout", Cout, 0);
    chk("mul9_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
